// File: rtl/enemy_lane_ctrl_if.sv
// Lane controller bus: game strobes and attacks in, enemy sprite state out.
interface enemy_lane_ctrl_if;
   logic       tick;
   logic       game_en;
   logic       atk_valid;
   logic [1:0] atk_lane;
   logic [4:0] pos;
   logic       hit;
   logic       kill;

   modport master (
      output tick, game_en, atk_valid, atk_lane,
      input  pos, hit, kill
   );

   modport slave (
      input  tick, game_en, atk_valid, atk_lane,
      output pos, hit, kill
   );
endinterface

// File: rtl/enemy_lane_ctrl.sv
// Single-lane enemy: random respawn delay, walk toward the player, strike,
// and a struck (hit) state when the player attacks this lane in range.
module enemy_lane_ctrl #(
   parameter int unsigned LANE      = 3,
   parameter int unsigned SPAWN_MIN = 4,
   parameter int unsigned KILL_MIN  = 6,
   parameter int unsigned ATK_TICKS = 8,
   parameter int unsigned HIT_TICKS = 6
) (
   input logic              clk,
   input logic              rst,
   enemy_lane_ctrl_if.slave bus
);

   localparam int unsigned POS_W    = 5;
   localparam int unsigned POS_LAST = 10;
   localparam int unsigned SPAWN_MX = SPAWN_MIN + 15;
   localparam int unsigned CNT_MX0  = (SPAWN_MX > ATK_TICKS) ? SPAWN_MX : ATK_TICKS;
   localparam int unsigned CNT_MAX  = (CNT_MX0 > HIT_TICKS) ? CNT_MX0 : HIT_TICKS;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_WALK   = 3'd2;
   localparam logic [2:0] S_STRIKE = 3'd3;
   localparam logic [2:0] S_HIT    = 3'd4;

   logic [2:0]       state, state_n;
   logic [POS_W-1:0] pos_q, pos_n;
   logic             hit_q, hit_n;
   logic             kill_q, kill_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [7:0]       lfsr_q, lfsr_n;
   logic [CNT_W-1:0] spawn_dly;
   logic             kill_cond;

   // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, advanced every clock
   always_comb begin
      lfsr_n = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Respawn delay taken from the current LFSR value; attack-in-range decode
   always_comb begin
      spawn_dly = CNT_W'(SPAWN_MIN) + CNT_W'(lfsr_q[3:0]);
      kill_cond = bus.atk_valid && (bus.atk_lane == 2'(LANE)) &&
                  (((state == S_WALK) && (pos_q >= POS_W'(KILL_MIN))) ||
                   (state == S_STRIKE));
   end

   // Next-state and next-output logic; game_en drop beats a kill, a kill beats a tick
   always_comb begin
      state_n = state;
      pos_n   = pos_q;
      hit_n   = hit_q;
      kill_n  = 1'b0;
      cnt_n   = cnt_q;
      if (!bus.game_en) begin
         state_n = S_IDLE;
         pos_n   = '0;
         hit_n   = 1'b0;
         cnt_n   = '0;
      end else if (kill_cond) begin
         state_n = S_HIT;
         hit_n   = 1'b1;
         kill_n  = 1'b1;
         cnt_n   = CNT_W'(HIT_TICKS);
      end else begin
         case (state)
            S_IDLE: begin
               state_n = S_WAIT;
               pos_n   = '0;
               hit_n   = 1'b0;
               cnt_n   = spawn_dly;
            end
            S_WAIT: begin
               if (bus.tick) begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_n = S_WALK;
                     pos_n   = POS_W'(1);
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt_q - CNT_W'(1);
                  end
               end
            end
            S_WALK: begin
               if (bus.tick) begin
                  if (pos_q >= POS_W'(POS_LAST - 1)) begin
                     state_n = S_STRIKE;
                     pos_n   = POS_W'(POS_LAST);
                     cnt_n   = CNT_W'(ATK_TICKS);
                  end else begin
                     pos_n = pos_q + POS_W'(1);
                  end
               end
            end
            S_STRIKE: begin
               if (bus.tick) begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_n = S_WAIT;
                     pos_n   = '0;
                     cnt_n   = spawn_dly;
                  end else begin
                     cnt_n = cnt_q - CNT_W'(1);
                  end
               end
            end
            S_HIT: begin
               if (bus.tick) begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_n = S_WAIT;
                     pos_n   = '0;
                     hit_n   = 1'b0;
                     cnt_n   = spawn_dly;
                  end else begin
                     cnt_n = cnt_q - CNT_W'(1);
                  end
               end
            end
            default: begin
               state_n = S_IDLE;
               pos_n   = '0;
               hit_n   = 1'b0;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // State, output and LFSR registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         pos_q  <= '0;
         hit_q  <= 1'b0;
         kill_q <= 1'b0;
         cnt_q  <= '0;
         lfsr_q <= LFSR_SEED;
      end else begin
         state  <= state_n;
         pos_q  <= pos_n;
         hit_q  <= hit_n;
         kill_q <= kill_n;
         cnt_q  <= cnt_n;
         lfsr_q <= lfsr_n;
      end
   end

   assign bus.pos  = pos_q;
   assign bus.hit  = hit_q;
   assign bus.kill = kill_q;

endmodule

// File: doc/enemy_lane_ctrl.md
ENEMY_LANE_CTRL -- requirements
Module: enemy_lane_ctrl

Interface
REQ-001 Parameter LANE, default 3, lane index this controller owns (0..3).
REQ-002 Parameter SPAWN_MIN, default 4, minimum respawn delay in ticks.
REQ-003 Parameter KILL_MIN, default 6, lowest walking position at which an attack kills.
REQ-004 Parameter ATK_TICKS, default 8, ticks the enemy holds at the player position.
REQ-005 Parameter HIT_TICKS, default 6, ticks the hit indication is held.
REQ-006 clk  input  1  system clock; sole clock of the block.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 tick  input  1  one-cycle step-enable pulse, the game-speed strobe.
REQ-009 game_en  input  1  level; high while a round is running.
REQ-010 atk_valid  input  1  one-cycle player-attack pulse.
REQ-011 atk_lane  input  2  lane targeted by the attack; qualified by atk_valid.
REQ-012 pos  output  5  enemy position for the sprite/damage stage: 0 = absent, 1..10 = walking toward player, 10 = at player.
REQ-013 hit  output  1  high while the enemy is in its struck state.
REQ-014 kill  output  1  one-cycle pulse on each successful kill, for the score counter.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, WALK, STRIKE and HIT; all outputs are registered.
REQ-016 IDLE: pos=0, hit=0; the FSM SHALL move to WAIT on the first clk with game_en=1.
REQ-017 The block SHALL contain an 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every clk.
REQ-018 On entering WAIT, the delay counter SHALL load SPAWN_MIN + lfsr[3:0], using the LFSR value of that cycle.
REQ-019 WAIT: pos=0; the counter SHALL decrement on each tick; on the tick that reaches 0, the FSM SHALL enter WALK with pos=1.
REQ-020 WALK: pos SHALL increment by 1 on each tick; the tick at pos=9 SHALL set pos=10 and enter STRIKE.
REQ-021 STRIKE: pos SHALL hold 10 for ATK_TICKS ticks; the FSM SHALL then set pos=0 and enter WAIT with a new delay.
REQ-022 A kill condition SHALL be atk_valid=1 and atk_lane==LANE, while in WALK with pos>=KILL_MIN or while in STRIKE.
REQ-023 A kill condition SHALL, on the next clk:
- enter HIT and freeze pos at its current value;
- set hit=1;
- pulse kill for exactly one cycle.
REQ-024 Attacks SHALL be ignored in IDLE, WAIT and HIT, in WALK below KILL_MIN, and when atk_lane differs from LANE.
REQ-025 HIT SHALL last HIT_TICKS ticks; on exit it SHALL set hit=0 and pos=0, then enter WAIT.
REQ-026 When tick and a kill condition occur in the same cycle, the kill SHALL take priority, and pos SHALL NOT advance.
REQ-027 A tick coinciding with the final HIT or STRIKE tick SHALL be consumed by that exit only; WAIT begins counting on the next tick.
REQ-028 When game_en=0 in any state, the next clk SHALL force IDLE with pos=0, hit=0 and kill=0; this takes priority over a kill condition.
REQ-029 All tick counters SHALL be wide enough for their parameter values without wrap-around; pos SHALL never exceed 10.

Reset
REQ-030 When rst=1 at a clk edge, the block SHALL set the state to IDLE, pos=0, hit=0 and kill=0.
REQ-031 The same reset SHALL set the LFSR to 8'hA5 and clear all counters; rst overrides every other input.
REQ-032 Reset asserted mid-WALK or mid-HIT SHALL take effect on that edge, with no residual kill pulse.

Verification
REQ-033 Scenario: after rst, set game_en=1 and pulse tick repeatedly. Required response: pos stays 0 for exactly SPAWN_MIN+lfsr[3:0] ticks, then steps 1..10 on successive ticks.
REQ-034 Scenario: enemy at pos=7; pulse atk_valid with atk_lane=3. Required response: next cycle hit=1, kill high for 1 cycle, pos held at 7; after 6 ticks, hit=0 and pos=0.
REQ-035 Scenario: enemy at pos=5, attack on lane 3; and enemy at pos=8, attack on lane 2. Required response: both attacks ignored, pos keeps advancing, kill stays 0.
REQ-036 Scenario: tick and a valid attack in the same cycle at pos=9. Required response: HIT entered with pos=9, not 10.
REQ-037 Scenario: enemy reaches pos=10 and no attack occurs. Required response: pos holds 10 for 8 ticks, then goes to 0 and a new WAIT begins.
REQ-038 Scenario: game_en drops during STRIKE, and separately rst is pulsed during HIT. Required response: next cycle pos=0, hit=0, kill=0, state IDLE.
